alu_op_controller: RTL and testbench

ALU_OP_CONTROLLER -- requirements
Module: alu_op_controller

---
 rtl/alu_op_controller_if.sv | 36 +++
 rtl/alu_op_controller.sv | 106 ++++++++++
 tb/tb_alu_op_controller.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_controller_if.sv
// Bundle of the request, result and ALU-side signals of alu_op_controller.
//   req_*  : operation request from the issuer (valid/ready handshake)
//   res_*  : captured result to the consumer (valid/ready handshake)
//   alu_*  : operands/selects/enable to the ALU selector stage, alu_y back
// slave  = controller view, master = environment (issuer, consumer, ALU) view.
interface alu_op_controller_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_a;
  logic [3:0] req_b;

  logic       res_valid;
  logic       res_ready;
  logic [4:0] res_y;
  logic [1:0] res_op;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_s0;
  logic       alu_s1;
  logic       alu_en;
  logic [4:0] alu_y;

  modport slave (
    input  req_valid, req_op, req_a, req_b, res_ready, alu_y,
    output req_ready, res_valid, res_y, res_op,
    output alu_a, alu_b, alu_s0, alu_s1, alu_en
  );

  modport master (
    output req_valid, req_op, req_a, req_b, res_ready, alu_y,
    input  req_ready, res_valid, res_y, res_op,
    input  alu_a, alu_b, alu_s0, alu_s1, alu_en
  );
endinterface

// File: rtl/alu_op_controller.sv
// Sequences one ALU operation at a time: latch request, drive the ALU for a
// single cycle, hold the captured result until the consumer takes it.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request / result / ALU signals (alu_op_controller_if.slave)
//   busy     : controller is not idle
//   op_count : number of delivered results, wraps silently
module alu_op_controller #(
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_controller_if.slave bus,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       op_q;
  logic [3:0]       a_q;
  logic [3:0]       b_q;
  logic [4:0]       y_q;
  logic [1:0]       rop_q;
  logic [CNT_W-1:0] cnt_q;

  logic             req_ready_c;
  logic             req_hs_c;
  logic             res_hs_c;

  // Handshake qualification and next-state; reset masks both handshakes.
  always_comb begin
    state_d     = state_q;
    req_ready_c = 1'b0;
    res_hs_c    = 1'b0;
    req_hs_c    = 1'b0;

    case (state_q)
      IDLE:    req_ready_c = 1'b1;
      DONE: begin
        // A new request is only taken when the pending result leaves.
        req_ready_c = bus.res_ready;
        res_hs_c    = bus.res_ready;
      end
      default: req_ready_c = 1'b0;
    endcase

    if (rst) begin
      req_ready_c = 1'b0;
      res_hs_c    = 1'b0;
    end
    req_hs_c = bus.req_valid & req_ready_c;

    case (state_q)
      IDLE:    if (req_hs_c) state_d = DRIVE;
      DRIVE:   state_d = DONE;
      DONE:    if (res_hs_c) state_d = req_hs_c ? DRIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand latch, result capture and delivery counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 2'd0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      y_q     <= 5'd0;
      rop_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (req_hs_c) begin
        op_q <= bus.req_op;
        a_q  <= bus.req_a;
        b_q  <= bus.req_b;
      end
      if (state_q == DRIVE) begin
        y_q   <= bus.alu_y;
        rop_q <= op_q;
      end
      if (res_hs_c) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_y     = y_q;
  assign bus.res_op    = rop_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_s0    = op_q[0];
  assign bus.alu_s1    = op_q[1];
  assign bus.alu_en    = (state_q == DRIVE);
  assign busy          = (state_q != IDLE);
  assign op_count      = cnt_q;

endmodule

// File: tb/tb_alu_op_controller.sv
// Self-checking bench for alu_op_controller: a behavioural ALU answers the
// controller, a scoreboard predicts each result when its request is accepted.
module tb_alu_op_controller;

  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] y;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  alu_op_controller_if bus ();

  alu_op_controller #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  int               n_checks = 0;
  int               n_errors = 0;
  int               cyc      = 0;
  exp_t             sb[$];
  int               pop_cyc[$];
  logic [CNT_W-1:0] exp_cnt  = '0;

  function automatic logic [4:0] alu_fn(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'd0:    alu_fn = 5'(a) + 5'(b);
      2'd1:    alu_fn = 5'(a) - 5'(b);
      2'd2:    alu_fn = {3'b000, (a > b), (a == b)};
      default: alu_fn = {1'b0, a & b};
    endcase
  endfunction

  assign bus.alu_y = alu_fn({bus.alu_s1, bus.alu_s0}, bus.alu_a, bus.alu_b);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change just after posedge, so a negedge sample shows exactly what
  // the next posedge will see.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_cnt = '0;
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_res_y", 32'(bus.res_y), 32'(e.y));
          check("sb_res_op", 32'(bus.res_op), 32'(e.op));
          check("sb_op_count", 32'(op_count), 32'(exp_cnt));
          exp_cnt = exp_cnt + CNT_W'(1);
          pop_cyc.push_back(cyc);
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        sb.push_back('{op: bus.req_op, y: alu_fn(bus.req_op, bus.req_a, bus.req_b)});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check({pfx, "_alu_en"},    32'(bus.alu_en),    32'd0);
    check({pfx, "_busy"},      32'(busy),          32'd0);
    check({pfx, "_res_y"},     32'(bus.res_y),     32'd0);
    check({pfx, "_res_op"},    32'(bus.res_op),    32'd0);
    check({pfx, "_alu_a"},     32'(bus.alu_a),     32'd0);
    check({pfx, "_alu_b"},     32'(bus.alu_b),     32'd0);
    check({pfx, "_alu_s"},     32'({bus.alu_s1, bus.alu_s0}), 32'd0);
    check({pfx, "_op_count"},  32'(op_count),      32'd0);
    check({pfx, "_req_ready"}, 32'(bus.req_ready), 32'd0);
  endtask

  // One operation from IDLE with res_ready=1, checking every phase.
  task automatic single_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [4:0] exp_y);
    logic [CNT_W-1:0] cnt0;
    logic [4:0]       y_drive;
    cnt0 = op_count;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(negedge clk);
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);
    check("idle_alu_en", 32'(bus.alu_en), 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a     = ~a;
    @(negedge clk);
    check("drive_alu_en", 32'(bus.alu_en), 32'd1);
    check("drive_sel", 32'({bus.alu_s1, bus.alu_s0}), 32'(op));
    check("drive_alu_a", 32'(bus.alu_a), 32'(a));
    check("drive_alu_b", 32'(bus.alu_b), 32'(b));
    check("drive_req_ready", 32'(bus.req_ready), 32'd0);
    check("drive_res_valid", 32'(bus.res_valid), 32'd0);
    check("drive_busy", 32'(busy), 32'd1);
    y_drive = bus.alu_y;
    @(negedge clk);
    check("done_res_valid", 32'(bus.res_valid), 32'd1);
    check("done_alu_en", 32'(bus.alu_en), 32'd0);
    check("done_res_y", 32'(bus.res_y), 32'(exp_y));
    check("done_res_y_vs_drive", 32'(bus.res_y), 32'(y_drive));
    check("done_res_op", 32'(bus.res_op), 32'(op));
    @(negedge clk);
    check("after_res_valid", 32'(bus.res_valid), 32'd0);
    check("after_busy", 32'(busy), 32'd0);
    check("after_op_count", 32'(op_count), 32'(cnt0 + CNT_W'(1)));
  endtask

  // Continuous request stream with res_ready=1; waits for the pipe to drain.
  task automatic stream(input int n);
    int sent;
    int guard;
    sent  = 0;
    guard = 0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'($urandom_range(0, 3));
    bus.req_a     = 4'($urandom);
    bus.req_b     = 4'($urandom);
    while (sent < n && guard < n * 4 + 10) begin
      @(negedge clk);
      guard++;
      if (bus.req_ready) begin
        sent++;
        @(posedge clk);
        #1;
        if (sent < n) begin
          bus.req_op = 2'($urandom_range(0, 3));
          bus.req_a  = 4'($urandom);
          bus.req_b  = 4'($urandom);
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    bus.req_valid = 1'b0;
    check("stream_sent", 32'(sent), 32'(n));
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (busy && guard < 10);
    check("stream_drained", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [CNT_W-1:0] cnt0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_a     = 4'd0;
    bus.req_b     = 4'd0;
    bus.res_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("post_reset_busy", 32'(busy), 32'd0);

    // Single add 9+8
    bus.res_ready = 1'b1;
    single_op(2'd0, 4'd9, 4'd8, 5'd17);

    // Select mapping for every opcode
    for (int i = 0; i < 4; i++) begin
      logic [3:0] a;
      logic [3:0] b;
      a = 4'($urandom);
      b = 4'($urandom);
      single_op(2'(i), a, b, alu_fn(2'(i), a, b));
    end

    // Stall with req_* toggling
    bus.res_ready = 1'b0;
    cnt0 = op_count;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd3;
    bus.req_a     = 4'b1100;
    bus.req_b     = 4'b1010;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd0;
    bus.req_a     = 4'd1;
    bus.req_b     = 4'd2;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'($urandom);
      bus.req_op    = 2'($urandom);
      bus.req_a     = 4'($urandom);
      bus.req_b     = 4'($urandom);
      @(negedge clk);
      check("stall_res_valid", 32'(bus.res_valid), 32'd1);
      check("stall_res_y", 32'(bus.res_y), 32'b01000);
      check("stall_res_op", 32'(bus.res_op), 32'd3);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
      check("stall_alu_a", 32'(bus.alu_a), 32'b1100);
      check("stall_op_count", 32'(op_count), 32'(cnt0));
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall_release_count", 32'(op_count), 32'(cnt0 + CNT_W'(1)));
    check("stall_release_valid", 32'(bus.res_valid), 32'd0);

    // Back-to-back stream of 4
    apply_reset();
    pop_cyc.delete();
    stream(4);
    check("b2b_results", 32'(pop_cyc.size()), 32'd4);
    for (int i = 1; i < pop_cyc.size(); i++) begin
      check("b2b_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd2);
    end
    check("b2b_op_count", 32'(op_count), 32'd4);

    // Reset during DRIVE
    apply_reset();
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd3;
    bus.req_a     = 4'd15;
    bus.req_b     = 4'd7;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("rst_drive_pre", 32'(bus.alu_en), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("rst_drive");
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset during DONE, racing a result handshake
    bus.res_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd1;
    bus.req_a     = 4'd6;
    bus.req_b     = 4'd3;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_done_pre", 32'(bus.res_valid), 32'd1);
    rst           = 1'b1;
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("rst_done");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done_count", 32'(op_count), 32'd0);
    check("rst_done_idle", 32'(busy), 32'd0);

    // Counter wrap
    apply_reset();
    stream(256);
    check("wrap_256", 32'(op_count), 32'd0);
    stream(1);
    check("wrap_257", 32'(op_count), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
